reduce_pipe: RTL and testbench

- Parametrised, pipelined bitwise reduction unit for the processor ALU and its branch/compare paths.
- Reduces a WIDTH-bit operand to one bit. Supported ops: OR, AND, XOR (parity) and NOR (zero detect).
- Pipeline registers sit every LEVELS_PER_STAGE tree levels, so wide reductions close timing.
- A valid/ready handshake with backpressure lets the block sit between pipelined producers and consumers; a TAG_W sideband travels with each operand.

---
 rtl/reduce_pkg.sv | 49 ++++
 rtl/reduce_stage.sv | 47 ++++
 rtl/reduce_pipe.sv | 91 +++++++++
 tb/tb_reduce_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/reduce_pkg.sv
// Shared definitions for the pipelined bitwise reduction unit: op encodings,
// the padding identity, the 2-input gate and the tree/stage geometry helpers.
package reduce_pkg;

  localparam logic [1:0] MODE_OR  = 2'b00;
  localparam logic [1:0] MODE_AND = 2'b01;
  localparam logic [1:0] MODE_XOR = 2'b10;
  localparam logic [1:0] MODE_NOR = 2'b11;

  // Padding bit that leaves the reduction result unchanged.
  function automatic logic identity(input logic [1:0] mode);
    return (mode == MODE_AND);
  endfunction

  // NOR reduces as OR; the inversion is applied once at the pipe output.
  function automatic logic red2(input logic [1:0] mode, input logic a, input logic b);
    logic r;
    case (mode)
      MODE_AND: r = a & b;
      MODE_XOR: r = a ^ b;
      default:  r = a | b;
    endcase
    return r;
  endfunction

  function automatic int unsigned ceil_log2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  function automatic int unsigned stage_count(input int unsigned levels, input int unsigned lps);
    return (levels == 0) ? 1 : (levels + lps - 1) / lps;
  endfunction

  function automatic int unsigned stage_levels(input int unsigned levels, input int unsigned lps,
                                               input int unsigned k);
    int unsigned rem;
    rem = levels - k * lps;
    return (rem < lps) ? rem : lps;
  endfunction

  function automatic int unsigned stage_in_w(input int unsigned levels, input int unsigned lps,
                                             input int unsigned k);
    return 1 << (levels - k * lps);
  endfunction

endpackage

// File: rtl/reduce_stage.sv
// One pipeline stage: LEVELS levels of pairwise reduction followed by the
// valid/data/mode/tag register that loads when advance is high and holds otherwise.
module reduce_stage
  import reduce_pkg::*;
#(
  parameter int unsigned IN_W   = 4,
  parameter int unsigned LEVELS = 2,
  parameter int unsigned TAG_W  = 5,
  localparam int unsigned OUT_W = IN_W >> LEVELS
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             advance,
  input  logic             up_valid,
  input  logic [IN_W-1:0]  up_data,
  input  logic [1:0]       up_mode,
  input  logic [TAG_W-1:0] up_tag,
  output logic             valid,
  output logic [OUT_W-1:0] data,
  output logic [1:0]       mode,
  output logic [TAG_W-1:0] tag
);

  // Heap-indexed tree: leaves at [2*IN_W-1:IN_W], node i combines 2i and 2i+1.
  logic [2*IN_W-1:OUT_W] node;

  assign node[2*IN_W-1:IN_W] = up_data;

  for (genvar i = OUT_W; i < IN_W; i++) begin : g_node
    assign node[i] = red2(up_mode, node[2*i], node[2*i+1]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
      mode  <= '0;
      tag   <= '0;
    end else if (advance) begin
      valid <= up_valid;
      data  <= node[2*OUT_W-1:OUT_W];
      mode  <= up_mode;
      tag   <= up_tag;
    end
  end

endmodule

// File: rtl/reduce_pipe.sv
// Pipelined WIDTH-bit to 1-bit reduction (OR/AND/XOR/NOR) with valid/ready
// flow control; a register stage sits every LEVELS_PER_STAGE tree levels.
module reduce_pipe
  import reduce_pkg::*;
#(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned LEVELS_PER_STAGE = 2,
  parameter int unsigned TAG_W            = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned L  = ceil_log2(WIDTH);
  localparam int unsigned S  = stage_count(L, LEVELS_PER_STAGE);
  localparam int unsigned PW = 1 << L;

  logic [PW-1:0] padded;
  logic [S-1:0]  valid;
  logic [S:0]    advance;

  always_comb begin
    padded = {PW{identity(in_mode)}};
    padded[WIDTH-1:0] = in_data;
  end

  // A stage moves when it is empty or its successor moves; no path from in_valid.
  assign advance[S] = out_ready;
  for (genvar k = 0; k < S; k++) begin : g_adv
    assign advance[k] = ~valid[k] | advance[k+1];
  end
  assign in_ready = advance[0];

  for (genvar k = 0; k < S; k++) begin : g_stage
    localparam int unsigned IW = stage_in_w(L, LEVELS_PER_STAGE, k);
    localparam int unsigned LV = stage_levels(L, LEVELS_PER_STAGE, k);

    logic                up_valid;
    logic [IW-1:0]       up_data;
    logic [1:0]          up_mode;
    logic [TAG_W-1:0]    up_tag;
    logic [(IW>>LV)-1:0] data;
    logic [1:0]          mode;
    logic [TAG_W-1:0]    tag;

    if (k == 0) begin : g_src
      assign up_valid = in_valid;
      assign up_data  = padded;
      assign up_mode  = in_mode;
      assign up_tag   = in_tag;
    end else begin : g_src
      assign up_valid = valid[k-1];
      assign up_data  = g_stage[k-1].data;
      assign up_mode  = g_stage[k-1].mode;
      assign up_tag   = g_stage[k-1].tag;
    end

    reduce_stage #(
      .IN_W  (IW),
      .LEVELS(LV),
      .TAG_W (TAG_W)
    ) u_stage (
      .clock   (clock),
      .reset_n (reset_n),
      .advance (advance[k]),
      .up_valid(up_valid),
      .up_data (up_data),
      .up_mode (up_mode),
      .up_tag  (up_tag),
      .valid   (valid[k]),
      .data    (data),
      .mode    (mode),
      .tag     (tag)
    );
  end

  assign out_valid = valid[S-1];
  // Driven only by last-stage flops; cleared mode/data give out_bit=0 in reset.
  assign out_bit   = g_stage[S-1].data[0] ^ (g_stage[S-1].mode == MODE_NOR);
  assign out_tag   = g_stage[S-1].tag;

endmodule

// File: tb/tb_reduce_pipe.sv
// Scoreboarded bench for reduce_pipe over several WIDTH/LEVELS_PER_STAGE
// configurations, each with its own driver, reference model and monitor.
module tb_reduce_pipe;

  localparam int NCFG = 5;
  localparam int TW   = 5;

  typedef struct packed {
    logic          b;
    logic [TW-1:0] tag;
    logic          lat;
    int unsigned   cyc;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;
  logic [NCFG-1:0] done_vec;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int W   = (g == 0) ? 32 : (g == 1) ? 13 : (g == 2) ? 1 : (g == 3) ? 7 : 64;
    localparam int LPS = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 1 : 3;
    localparam int L   = $clog2(W);
    localparam int S   = (L == 0) ? 1 : (L + LPS - 1) / LPS;

    logic          reset_n, in_valid, in_ready, out_valid, out_ready, out_bit;
    logic [W-1:0]  in_data;
    logic [1:0]    in_mode;
    logic [TW-1:0] in_tag, out_tag;
    exp_t          q[$];
    exp_t          e;
    int unsigned   cyc = 0;
    logic          done = 1'b0;

    assign done_vec[g] = done;

    reduce_pipe #(
      .WIDTH           (W),
      .LEVELS_PER_STAGE(LPS),
      .TAG_W           (TW)
    ) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_mode  (in_mode),
      .in_tag   (in_tag),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_bit  (out_bit),
      .out_tag  (out_tag)
    );

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic model(input logic [W-1:0] d, input logic [1:0] m);
      case (m)
        2'b00:   return |d;
        2'b01:   return &d;
        2'b10:   return ^d;
        default: return ~|d;
      endcase
    endfunction

    function automatic logic [W-1:0] pat(input int p);
      logic [W-1:0] v;
      v = '0;
      case (p)
        1: v = '1;
        2: begin v = '1; v[0] = 1'b0; end
        3: v = W'(32'd7);
        4: v = W'(32'd3);
        5: v[W-1] = 1'b1;
        default: ;
      endcase
      return v;
    endfunction

    function automatic logic [W-1:0] rnd_data();
      logic [63:0] r;
      logic [W-1:0] v;
      r = {$urandom, $urandom};
      v = r[W-1:0];
      case ($urandom_range(0, 4))
        1: v = '1;
        2: v = '0;
        3: begin v = '0; v[$urandom_range(0, W-1)] = 1'b1; end
        4: begin v = '1; v[$urandom_range(0, W-1)] = 1'b0; end
        default: ;
      endcase
      return v;
    endfunction

    // One cycle of stimulus; a transfer seen here is pushed to the scoreboard.
    task automatic step(input logic v, input logic [W-1:0] d, input logic [1:0] m,
                        input logic [TW-1:0] t, input logic ordy, input logic lat,
                        output logic acc);
      exp_t x;
      @(negedge clock);
      in_valid  = v;
      in_data   = d;
      in_mode   = m;
      in_tag    = t;
      out_ready = ordy;
      #1;
      acc = in_valid && in_ready;
      if (acc) begin
        x.b   = model(d, m);
        x.tag = t;
        x.lat = lat;
        x.cyc = cyc;
        q.push_back(x);
      end
    endtask

    task automatic drain();
      logic acc;
      for (int i = 0; i < 200 && q.size() > 0; i++) step(1'b0, '0, 2'b00, '0, 1'b1, 1'b0, acc);
      chk($sformatf("c%0d drain queue size", g), 64'(q.size()), 64'd0);
    endtask

    always @(negedge clock) begin
      #2;
      if (reset_n && out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL c%0d unexpected output: got tag %0h, want no output", g, out_tag);
        end else begin
          e = q.pop_front();
          chk($sformatf("c%0d out_bit", g), 64'(out_bit), 64'(e.b));
          chk($sformatf("c%0d out_tag", g), 64'(out_tag), 64'(e.tag));
          if (e.lat) chk($sformatf("c%0d latency", g), 64'(cyc - e.cyc), 64'(S));
        end
      end
    end

    initial begin
      logic acc;
      logic hold_bit;
      logic [TW-1:0] hold_tag;
      int n_acc;

      reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0; in_tag = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      chk($sformatf("c%0d reset out_valid", g), 64'(out_valid), 64'd0);
      chk($sformatf("c%0d reset out_bit", g), 64'(out_bit), 64'd0);
      chk($sformatf("c%0d reset out_tag", g), 64'(out_tag), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      chk($sformatf("c%0d in_ready after reset", g), 64'(in_ready), 64'd1);

      // Directed patterns x all ops, back to back, no backpressure.
      for (int p = 0; p < 6; p++) begin
        for (int m = 0; m < 4; m++) begin
          step(1'b1, pat(p), 2'(m), TW'(p * 4 + m), 1'b1, 1'b1, acc);
          chk($sformatf("c%0d streaming accept", g), 64'(acc), 64'd1);
        end
      end
      drain();

      // Backpressure: one operand parks at the output, upstream must still fill.
      step(1'b1, pat(1), 2'b01, TW'(20), 1'b0, 1'b0, acc);
      repeat (S + 1) step(1'b0, '0, 2'b00, '0, 1'b0, 1'b0, acc);
      chk($sformatf("c%0d parked out_valid", g), 64'(out_valid), 64'd1);
      chk($sformatf("c%0d bubble in_ready", g), 64'(in_ready), 64'(S > 1));
      n_acc = 0;
      for (int i = 0; i < S + 2; i++) begin
        step(1'b1, rnd_data(), 2'($urandom), TW'(21 + i), 1'b0, 1'b0, acc);
        n_acc += int'(acc);
      end
      chk($sformatf("c%0d accepted while stalled", g), 64'(n_acc), 64'(S - 1));
      chk($sformatf("c%0d full in_ready", g), 64'(in_ready), 64'd0);
      hold_bit = out_bit;
      hold_tag = out_tag;
      repeat (3) step(1'b1, rnd_data(), 2'($urandom), TW'(30), 1'b0, 1'b0, acc);
      chk($sformatf("c%0d stalled out_bit stable", g), 64'(out_bit), 64'(hold_bit));
      chk($sformatf("c%0d stalled out_tag stable", g), 64'(out_tag), 64'(hold_tag));
      step(1'b1, pat(0), 2'b11, TW'(31), 1'b1, 1'b0, acc);
      chk($sformatf("c%0d full pipe with out_ready accepts", g), 64'(acc), 64'd1);
      drain();

      // Asynchronous reset mid-cycle with operands in flight.
      for (int i = 0; i < 3; i++) step(1'b1, rnd_data(), 2'($urandom), TW'(8 + i), 1'b1, 1'b0, acc);
      @(posedge clock);
      #3;
      reset_n  = 1'b0;
      in_valid = 1'b0;
      #1;
      chk($sformatf("c%0d mid reset out_valid", g), 64'(out_valid), 64'd0);
      chk($sformatf("c%0d mid reset out_bit", g), 64'(out_bit), 64'd0);
      chk($sformatf("c%0d mid reset out_tag", g), 64'(out_tag), 64'd0);
      q.delete();
      @(negedge clock);
      reset_n = 1'b1;
      step(1'b1, pat(5), 2'b10, TW'(25), 1'b1, 1'b1, acc);
      drain();

      // Random traffic with random stalls on both sides.
      for (int i = 0; i < 2000; i++) begin
        step($urandom_range(0, 9) < 7, rnd_data(), 2'($urandom), TW'($urandom),
             $urandom_range(0, 9) < 7, 1'b0, acc);
      end
      drain();
      done = 1'b1;
    end
  end

  initial begin
    int unsigned t;
    t = 0;
    while (done_vec != '1 && t < 50000) begin
      @(posedge clock);
      t++;
    end
    if (done_vec != '1) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout: done=%b, want all ones", done_vec);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
